// File: rtl/paddle_axis_ctrl.sv
// Single-axis paddle tracker: turns debounced up/down levels into a paddle centre
// line with stepwise acceleration, clamp-or-wrap limits, recentre and edge flags.
module paddle_axis_ctrl #(
    parameter int Y_RES        = 480,
    parameter int PADDLE_H     = 64,
    parameter int TICKS_PER_PX = 200000,
    parameter int ACCEL_PX     = 16,
    parameter int MAX_LEVEL    = 3,
    parameter int POS_W        = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             game_on_i,
    input  logic             wrap_mode_i,
    input  logic             recenter_i,
    output logic [POS_W-1:0] position_o,
    output logic             moving_up_o,
    output logic             moving_down_o,
    output logic             at_top_o,
    output logic             at_bottom_o,
    output logic [1:0]       speed_level_o
);

    localparam logic [POS_W-1:0] PMIN = POS_W'(PADDLE_H / 2);
    localparam logic [POS_W-1:0] PMAX = POS_W'(Y_RES - 1 - PADDLE_H / 2);
    localparam logic [POS_W-1:0] PMID = POS_W'(Y_RES / 2);
    localparam int CNT_W    = (TICKS_PER_PX > 2) ? $clog2(TICKS_PER_PX) : 1;
    localparam int ACC_W    = (ACCEL_PX > 1) ? $clog2(ACCEL_PX + 1) : 1;
    // Levels beyond floor(log2(TICKS_PER_PX)) would give a zero-length period.
    localparam int LOG2_TPP = $clog2(TICKS_PER_PX + 1) - 1;
    localparam logic [1:0] LVL_CAP = 2'((MAX_LEVEL < LOG2_TPP) ? MAX_LEVEL : LOG2_TPP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]         lvl_q, lvl_d;
    logic               mu_q, mu_d;
    logic               md_q, md_d;
    logic               top_q, bot_q;

    logic               req_up_s, req_dn_s, req_same_s, req_other_s;
    logic               step_due_s, at_lim_s, step_taken_s;
    logic [31:0]        period_m1_s;
    logic [POS_W-1:0]   pos_step_s, wrap_tgt_s;

    assign req_up_s    = up_i & ~down_i;
    assign req_dn_s    = down_i & ~up_i;
    assign req_same_s  = (state_q == ST_UP) ? req_up_s : req_dn_s;
    assign req_other_s = (state_q == ST_UP) ? req_dn_s : req_up_s;
    assign period_m1_s = (32'(TICKS_PER_PX) >> lvl_q) - 32'd1;
    assign step_due_s  = (32'(cnt_q) == period_m1_s);
    assign at_lim_s    = (state_q == ST_UP) ? (pos_q == PMIN) : (pos_q == PMAX);
    assign pos_step_s  = (state_q == ST_UP) ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
    assign wrap_tgt_s  = (state_q == ST_UP) ? PMAX : PMIN;

    // Next-state, position, step timing and acceleration bookkeeping.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        lvl_d        = lvl_q;
        mu_d         = 1'b0;
        md_d         = 1'b0;
        step_taken_s = 1'b0;
        if (recenter_i) begin
            pos_d = PMID;
            cnt_d = {CNT_W{1'b0}};
            acc_d = {ACC_W{1'b0}};
            lvl_d = 2'd0;
        end else if ((pos_q < PMIN) || (pos_q > PMAX)) begin
            if (wrap_mode_i) begin
                pos_d = (pos_q < PMIN) ? PMAX : PMIN;
            end else begin
                pos_d = (pos_q < PMIN) ? PMIN : PMAX;
            end
            cnt_d = {CNT_W{1'b0}};
        end else if (!game_on_i) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            acc_d   = {ACC_W{1'b0}};
            lvl_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_up_s) begin
                        state_d = ST_UP;
                    end else if (req_dn_s) begin
                        state_d = ST_DOWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    cnt_d = {CNT_W{1'b0}};
                    acc_d = {ACC_W{1'b0}};
                    lvl_d = 2'd0;
                end
                ST_UP, ST_DOWN: begin
                    if (req_same_s) begin
                        if (step_due_s) begin
                            cnt_d = {CNT_W{1'b0}};
                            if (!at_lim_s) begin
                                pos_d        = pos_step_s;
                                step_taken_s = 1'b1;
                            end else if (wrap_mode_i) begin
                                pos_d        = wrap_tgt_s;
                                step_taken_s = 1'b1;
                            end else begin
                                pos_d = pos_q;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = req_other_s ? ((state_q == ST_UP) ? ST_DOWN : ST_UP) : ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                        acc_d   = {ACC_W{1'b0}};
                        lvl_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    acc_d   = {ACC_W{1'b0}};
                    lvl_d   = 2'd0;
                end
            endcase
        end
        if (step_taken_s) begin
            mu_d = (state_q == ST_UP);
            md_d = (state_q == ST_DOWN);
            if (acc_q == ACC_W'(ACCEL_PX - 1)) begin
                acc_d = {ACC_W{1'b0}};
                lvl_d = (lvl_q < LVL_CAP) ? (lvl_q + 2'd1) : lvl_q;
            end else begin
                acc_d = acc_q + ACC_W'(1);
            end
        end else begin
            mu_d = 1'b0;
            md_d = 1'b0;
        end
    end

    // State and output registers; edge flags follow the next position so they never lag.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            pos_q   <= PMID;
            cnt_q   <= {CNT_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            lvl_q   <= 2'd0;
            mu_q    <= 1'b0;
            md_q    <= 1'b0;
            top_q   <= 1'b0;
            bot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lvl_q   <= lvl_d;
            mu_q    <= mu_d;
            md_q    <= md_d;
            top_q   <= (pos_d == PMIN);
            bot_q   <= (pos_d == PMAX);
        end
    end

    assign position_o    = pos_q;
    assign moving_up_o   = mu_q;
    assign moving_down_o = md_q;
    assign at_top_o      = top_q;
    assign at_bottom_o   = bot_q;
    assign speed_level_o = lvl_q;

endmodule

// File: tb/tb_paddle_axis_ctrl.sv
// Bench for paddle_axis_ctrl: fixed vector table, hand-built corner sequences and a
// randomized run checked against a direction/period reference model.
module tb_paddle_axis_ctrl;

    localparam int TPP  = 4;
    localparam int ACC  = 2;
    localparam int MAXL = 3;
    localparam int YR   = 480;
    localparam int PH   = 64;
    localparam int PW   = 10;
    localparam int PMIN = PH / 2;
    localparam int PMAX = YR - 1 - PH / 2;
    localparam int PMID = YR / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, up, down, game_on, wrap_mode, recenter;
    logic [PW-1:0] position;
    logic          moving_up, moving_down, at_top, at_bottom;
    logic [1:0]    speed_level;

    paddle_axis_ctrl #(
        .Y_RES(YR), .PADDLE_H(PH), .TICKS_PER_PX(TPP),
        .ACCEL_PX(ACC), .MAX_LEVEL(MAXL), .POS_W(PW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .up_i(up), .down_i(down),
        .game_on_i(game_on), .wrap_mode_i(wrap_mode), .recenter_i(recenter),
        .position_o(position), .moving_up_o(moving_up), .moving_down_o(moving_down),
        .at_top_o(at_top), .at_bottom_o(at_bottom), .speed_level_o(speed_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: direction as -1/0/+1, ticks since entry or last step, level, steps at level.
    int m_pos, m_dir, m_cnt, m_lvl, m_acc, m_mu, m_md, m_top, m_bot, m_cap;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_cycle();
        int req, period, nxt;
        bit stepped;
        if (!reset) begin
            m_pos = PMID; m_dir = 0; m_cnt = 0; m_lvl = 0; m_acc = 0;
            m_mu = 0; m_md = 0; m_top = 0; m_bot = 0;
            return;
        end
        req = (up && !down) ? -1 : ((down && !up) ? 1 : 0);
        m_mu = 0; m_md = 0; stepped = 0;
        if (recenter) begin
            m_pos = PMID; m_cnt = 0; m_lvl = 0; m_acc = 0;
        end else if (!game_on) begin
            m_dir = 0; m_cnt = 0; m_lvl = 0; m_acc = 0;
        end else if (req != m_dir) begin
            m_dir = req; m_cnt = 0; m_lvl = 0; m_acc = 0;
        end else if (m_dir != 0) begin
            period = TPP >> m_lvl;
            if (m_cnt == period - 1) begin
                m_cnt = 0;
                nxt = m_pos + m_dir;
                if (nxt < PMIN || nxt > PMAX) begin
                    if (wrap_mode) begin
                        m_pos = (nxt < PMIN) ? PMAX : PMIN;
                        stepped = 1;
                    end
                end else begin
                    m_pos = nxt;
                    stepped = 1;
                end
                if (stepped) begin
                    if (m_dir < 0) m_mu = 1; else m_md = 1;
                    m_acc++;
                    if (m_acc == ACC) begin
                        m_acc = 0;
                        if (m_lvl < m_cap) m_lvl++;
                    end
                end
            end else begin
                m_cnt++;
            end
        end
        m_top = (m_pos == PMIN) ? 1 : 0;
        m_bot = (m_pos == PMAX) ? 1 : 0;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input int u, input int d, input int g, input int w, input int rc);
        reset = r[0]; up = u[0]; down = d[0]; game_on = g[0]; wrap_mode = w[0]; recenter = rc[0];
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pos"}, int'(position), m_pos);
        check({tag, ".mu"}, int'(moving_up), m_mu);
        check({tag, ".md"}, int'(moving_down), m_md);
        check({tag, ".top"}, int'(at_top), m_top);
        check({tag, ".bot"}, int'(at_bottom), m_bot);
        check({tag, ".lvl"}, int'(speed_level), m_lvl);
    endtask

    typedef struct {
        int rst, u, d, g, w, rc;
        int pos, mu, md, top, bot, lvl;
    } vec_t;

    vec_t tbl[20];
    int   exp_int[7] = '{4, 4, 2, 2, 1, 1, 1};
    int   exp_lvl[7] = '{0, 1, 1, 2, 2, 2, 2};

    initial begin
        int cyc, bad;
        m_cap = MAXL;
        while ((TPP >> m_cap) == 0) m_cap--;
        drive(0, 0, 0, 0, 0, 0);

        // reset, up press with first step 4 cycles after entry, both-pressed stop,
        // down press, reversal, freeze and recentre while frozen
        tbl[0]  = '{0, 0, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 0, 0, 239, 1, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 1, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 1, 1, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 1, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 1, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 1, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 1, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 1, 1, 0, 0, 240, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 0, 1, 0, 0, 240, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 1, 0, 0, 239, 1, 0, 0, 0, 0};
        tbl[18] = '{1, 1, 0, 0, 0, 0, 239, 0, 0, 0, 0, 0};
        tbl[19] = '{1, 1, 0, 0, 0, 1, 240, 0, 0, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].u, tbl[i].d, tbl[i].g, tbl[i].w, tbl[i].rc);
            tick();
            check($sformatf("vec%0d.pos", i), int'(position), tbl[i].pos);
            check($sformatf("vec%0d.mu", i), int'(moving_up), tbl[i].mu);
            check($sformatf("vec%0d.md", i), int'(moving_down), tbl[i].md);
            check($sformatf("vec%0d.top", i), int'(at_top), tbl[i].top);
            check($sformatf("vec%0d.bot", i), int'(at_bottom), tbl[i].bot);
            check($sformatf("vec%0d.lvl", i), int'(speed_level), tbl[i].lvl);
        end

        // acceleration: down held from 240, intervals 4,4,2,2,1,1,1, level saturates at 2
        drive(1, 0, 1, 1, 0, 0);
        tick();
        for (int k = 0; k < 7; k++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!moving_down && cyc < 20);
            check($sformatf("accel_int%0d", k), cyc, exp_int[k]);
            check($sformatf("accel_lvl%0d", k), int'(speed_level), exp_lvl[k]);
        end
        check("accel_pos", int'(position), 247);

        // clamp at the top: run up to PMIN, then keep pushing
        drive(1, 1, 0, 1, 0, 0);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (int'(position) != PMIN && cyc < 600);
        check("clamp_reach", int'(position), PMIN);
        check("clamp_at_top", int'(at_top), 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (moving_up || int'(position) != PMIN || !at_top) bad++;
        end
        check("clamp_hold", bad, 0);
        check("clamp_lvl", int'(speed_level), 2);

        // wrap: up at PMIN goes to PMAX; reversal then down at PMAX goes to PMIN
        wrap_mode = 1'b1;
        tick();
        check("wrap_up_pos", int'(position), PMAX);
        check("wrap_up_mu", int'(moving_up), 1);
        check("wrap_up_bot", int'(at_bottom), 1);
        drive(1, 0, 1, 1, 1, 0);
        tick();
        check("rev_no_step", int'(position), PMAX);
        check("rev_lvl", int'(speed_level), 0);
        for (int k = 0; k < 3; k++) tick();
        check("wrap_dn_early", int'(position), PMAX);
        tick();
        check("wrap_dn_pos", int'(position), PMIN);
        check("wrap_dn_md", int'(moving_down), 1);
        check("wrap_dn_top", int'(at_top), 1);

        // recentre lands on a step cycle: step dropped, state kept
        for (int k = 0; k < 3; k++) tick();
        recenter = 1'b1;
        tick();
        check("rc_pos", int'(position), PMID);
        check("rc_md", int'(moving_down), 0);
        recenter = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("rc_next_pos", int'(position), PMID + 1);
        check("rc_next_md", int'(moving_down), 1);

        // reset mid-move
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_pos", int'(position), PMID);
        check("rst_flags", int'({moving_up, moving_down, at_top, at_bottom}), 0);
        check("rst_lvl", int'(speed_level), 0);
        reset = 1'b1;
        tick();
        check_model("post_rst");

        // randomized run against the reference model
        wrap_mode = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 31) == 0) up = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) down = $urandom_range(0, 1);
            game_on = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 199) == 0) wrap_mode = ~wrap_mode;
            recenter = ($urandom_range(0, 149) == 0);
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
